serv_mem_arbiter: RTL and testbench
===================================

# serv_mem_arbiter

Registered, round-robin Wishbone arbiter that shares the single external memory port between the SERV instruction bus and data bus. It sits between `serv_rf_top` and the scan-chain bus bridge. It presents one clean, glitch-free, registered master transaction at a time. An optional watchdog terminates transactions that the scan-chain host never acknowledges.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width; `sel` width is `DW/8`
- `TIMEOUT_CYCLES`, 255, cycles spent in BUSY without `i_mem_ack` before forced termination; legal range 1..65535

Ports:
- `clk`  in  1  single clock, rising edge
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_ibus_adr`  in  AW  instruction fetch address
- `i_ibus_cyc`  in  1  instruction fetch request
- `o_ibus_rdt`  out  DW  fetched instruction
- `o_ibus_ack`  out  1  one-cycle fetch completion
- `i_dbus_adr`  in  AW  data address
- `i_dbus_dat`  in  DW  write data
- `i_dbus_sel`  in  DW/8  byte enables
- `i_dbus_we`  in  1  write enable
- `i_dbus_cyc`  in  1  data request
- `o_dbus_rdt`  out  DW  read data
- `o_dbus_ack`  out  1  one-cycle data completion
- `o_mem_adr`, `o_mem_dat`, `o_mem_sel`, `o_mem_we`, `o_mem_cyc`  out  AW/DW/DW/8/1/1  registered shared master
- `i_mem_rdt`  in  DW  memory read data
- `i_mem_ack`  in  1  memory acknowledge, one-cycle pulse
- `o_timeout`  out  1  one-cycle pulse on watchdog termination
- `o_busy`  out  1  high in BUSY and ACK states

## Operation
- FSM states: IDLE, BUSY, ACK. Reset puts the FSM in IDLE and sets `last_grant` = IBUS.
- IDLE, when at least one `cyc` is high:
  - Choose the winner. If only one requester is active, it wins. If both are active, the requester not named by `last_grant` wins, so dbus wins the first tie after reset.
  - Register the winner's adr/dat/sel/we into `o_mem_*`. An ibus grant drives `we`=0, `sel`=all ones and `dat`=0.
  - Set `o_mem_cyc`=1, update `last_grant`, and go to BUSY.
- BUSY: hold all `o_mem_*` stable.
  - On `i_mem_ack`: capture `i_mem_rdt` into the winner's `rdt` register, pulse the winner's `ack`, clear `o_mem_cyc`, and go to ACK.
- ACK: lasts exactly one cycle with no new grant, then returns to IDLE.
  - Requesters must drop `cyc` in the cycle after seeing `ack`, which SERV does.
- `o_ibus_rdt` and `o_dbus_rdt` hold their last captured value until the next completion for that bus.
- When not granted, `o_mem_adr`, `o_mem_dat`, `o_mem_sel` and `o_mem_we` hold their last values.
- A requester that drops `cyc` while in BUSY does not abort the transaction; it still completes and the `ack` still pulses.
- `i_mem_ack` seen in IDLE or ACK is ignored.

## Timing
- Reset values: all outputs 0, including `rdt`, `ack`, `o_mem_*`, `o_timeout` and `o_busy`.
- Reset asserted mid-transaction clears all outputs and state immediately (asynchronously); no `ack` is issued.
- Grant latency: a request first seen high in IDLE at cycle N gives `o_mem_cyc`=1 at N+1.
- Completion latency: `i_mem_ack` at cycle M gives requester `ack` and `rdt` valid at M+1, `o_mem_cyc`=0 at M+1, and IDLE at M+2.
- Minimum spacing between transactions is 3 cycles, from one `o_mem_cyc` rise to the next.

## Configuration
- Macro: `SERV_MEM_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without `i_mem_ack`.
  - When the count reaches `TIMEOUT_CYCLES`, the FSM goes to ACK and returns `rdt` = all ones with an `ack` pulse. `o_timeout` pulses in the same cycle as that `ack`, and `o_mem_cyc` clears.
  - If `i_mem_ack` arrives in the expiry cycle, the ack wins: real data is returned and there is no `o_timeout`.
- Undefined: BUSY waits indefinitely, the counter is absent, and `o_timeout` is tied to 0.

## Structure
- Package `serv_mem_arb_pkg` holds:
  - State enum: IDLE, BUSY, ACK
  - Grant enum: IBUS, DBUS
  - `TIMEOUT_RDT` constant (all ones)
- Sub-module `serv_mem_arb_watchdog`:
  - Parameter `TIMEOUT_CYCLES`; count width is $clog2(TIMEOUT_CYCLES+1).
  - Inputs: `clk`, `i_rst_n`, clear, run.
  - Output: expire pulse.
  - Instantiated only under the macro.

## Test plan
- Single ibus fetch at adr 0x100, memory acks after 5 cycles with 0x00000013 -> `o_mem_cyc` rises 1 cycle after request; `o_ibus_ack` pulses 1 cycle after `i_mem_ack` with `o_ibus_rdt`=0x00000013; `we`=0, `sel`=0xF.
- dbus write of 0xDEADBEEF, `sel`=0x3, to 0x2000 -> `o_mem_*` match and stay stable through BUSY; `o_dbus_ack` pulses once; `o_ibus_ack` never pulses.
- Both `cyc` high continuously across 4 transactions after reset -> grant order is dbus, ibus, dbus, ibus.
- Macro defined, `TIMEOUT_CYCLES`=8, memory never acks -> `o_timeout` and `o_dbus_ack` pulse together 9 cycles after `o_mem_cyc` rises, `rdt`=0xFFFFFFFF; a second run with ack on the expiry cycle returns real data and no timeout.
- `i_rst_n` low during BUSY -> all outputs 0 immediately; after release, a fresh request is granted normally with no stale `ack`.
- Spurious `i_mem_ack` in IDLE -> no `ack` on either bus and `rdt` values unchanged.

Source files
------------

// File: rtl/serv_mem_arb_pkg.sv
// Shared types and constants for the SERV ibus/dbus memory arbiter.
package serv_mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Which bus owns (or last owned) the shared memory port
    typedef enum logic {
        IBUS = 1'b0,
        DBUS = 1'b1
    } grant_e;

    // Read data returned on a watchdog termination; sliced down to DW by users
    localparam int                MAX_DW      = 256;
    localparam logic [MAX_DW-1:0] TIMEOUT_RDT = '1;

endpackage

// File: rtl/serv_mem_arb_watchdog.sv
// BUSY-state watchdog: counts cycles without an acknowledge and flags expiry.
// Only built when SERV_MEM_ARB_TIMEOUT_EN is defined.
module serv_mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);

    localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    // Clear on grant, count every waiting BUSY cycle; expiry leaves BUSY so no wrap
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clear) begin
            cnt <= '0;
        end else if (i_run) begin
            cnt <= cnt + CW'(1);
        end
    end

    // run already excludes an ack cycle, so a real ack always beats expiry
    assign o_expire = i_run && (cnt == LIMIT);

endmodule

// File: rtl/serv_mem_arbiter.sv
// Registered round-robin Wishbone arbiter sharing one memory port between the
// SERV instruction and data buses. Optional watchdog: SERV_MEM_ARB_TIMEOUT_EN.
module serv_mem_arbiter
    import serv_mem_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic [AW-1:0]   i_ibus_adr,
    input  logic            i_ibus_cyc,
    output logic [DW-1:0]   o_ibus_rdt,
    output logic            o_ibus_ack,
    input  logic [AW-1:0]   i_dbus_adr,
    input  logic [DW-1:0]   i_dbus_dat,
    input  logic [DW/8-1:0] i_dbus_sel,
    input  logic            i_dbus_we,
    input  logic            i_dbus_cyc,
    output logic [DW-1:0]   o_dbus_rdt,
    output logic            o_dbus_ack,
    output logic [AW-1:0]   o_mem_adr,
    output logic [DW-1:0]   o_mem_dat,
    output logic [DW/8-1:0] o_mem_sel,
    output logic            o_mem_we,
    output logic            o_mem_cyc,
    input  logic [DW-1:0]   i_mem_rdt,
    input  logic            i_mem_ack,
    output logic            o_timeout,
    output logic            o_busy
);

    state_e        state, state_nxt;
    grant_e        last_grant;
    logic          req_any, pick_dbus, start, mem_done, expire, finish;
    logic [DW-1:0] done_rdt;

    assign req_any   = i_ibus_cyc | i_dbus_cyc;
    // dbus wins when alone, or on a tie when ibus had the previous grant
    assign pick_dbus = i_dbus_cyc & (~i_ibus_cyc | (last_grant == IBUS));
    assign start     = (state == IDLE) & req_any;
    // acks outside BUSY are ignored
    assign mem_done  = (state == BUSY) & i_mem_ack;
    assign finish    = mem_done | expire;
    assign done_rdt  = mem_done ? i_mem_rdt : TIMEOUT_RDT[DW-1:0];
    assign o_busy    = (state != IDLE);

`ifdef SERV_MEM_ARB_TIMEOUT_EN
    logic wd_run;
    assign wd_run = (state == BUSY) & ~i_mem_ack;

    serv_mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (start),
        .i_run    (wd_run),
        .o_expire (expire)
    );

    // Timeout flag lines up with the requester ack it terminates
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) o_timeout <= 1'b0;
        else          o_timeout <= expire;
    end
`else
    // Timeout length only matters when the watchdog is built
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state: ACK is a single dead cycle before the next grant
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = BUSY;
            BUSY:    if (finish)  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered master port, grant tracking and per-bus response registers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= IBUS;
            o_mem_adr  <= '0;
            o_mem_dat  <= '0;
            o_mem_sel  <= '0;
            o_mem_we   <= 1'b0;
            o_mem_cyc  <= 1'b0;
            o_ibus_rdt <= '0;
            o_ibus_ack <= 1'b0;
            o_dbus_rdt <= '0;
            o_dbus_ack <= 1'b0;
        end else begin
            o_ibus_ack <= 1'b0;
            o_dbus_ack <= 1'b0;
            if (start) begin
                o_mem_cyc <= 1'b1;
                if (pick_dbus) begin
                    last_grant <= DBUS;
                    o_mem_adr  <= i_dbus_adr;
                    o_mem_dat  <= i_dbus_dat;
                    o_mem_sel  <= i_dbus_sel;
                    o_mem_we   <= i_dbus_we;
                end else begin
                    // instruction fetches are always full-word reads
                    last_grant <= IBUS;
                    o_mem_adr  <= i_ibus_adr;
                    o_mem_dat  <= '0;
                    o_mem_sel  <= '1;
                    o_mem_we   <= 1'b0;
                end
            end
            if (finish) begin
                // last_grant names the current owner while BUSY
                o_mem_cyc <= 1'b0;
                if (last_grant == DBUS) begin
                    o_dbus_rdt <= done_rdt;
                    o_dbus_ack <= 1'b1;
                end else begin
                    o_ibus_rdt <= done_rdt;
                    o_ibus_ack <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// Self-checking bench for serv_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_serv_mem_arbiter;

    localparam int T_CYC = 8;
`ifdef SERV_MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_ibus_adr, i_dbus_adr, i_dbus_dat, i_mem_rdt;
    logic        i_ibus_cyc, i_dbus_cyc, i_dbus_we, i_mem_ack;
    logic [3:0]  i_dbus_sel;
    logic [31:0] o_ibus_rdt, o_dbus_rdt, o_mem_adr, o_mem_dat;
    logic        o_ibus_ack, o_dbus_ack, o_mem_we, o_mem_cyc, o_timeout, o_busy;
    logic [3:0]  o_mem_sel;
    logic [137:0] all_out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign all_out = {o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_mem_adr,
                      o_mem_dat, o_mem_sel, o_mem_we, o_mem_cyc, o_timeout, o_busy};

    serv_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(T_CYC)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_ibus_adr (i_ibus_adr),
        .i_ibus_cyc (i_ibus_cyc),
        .o_ibus_rdt (o_ibus_rdt),
        .o_ibus_ack (o_ibus_ack),
        .i_dbus_adr (i_dbus_adr),
        .i_dbus_dat (i_dbus_dat),
        .i_dbus_sel (i_dbus_sel),
        .i_dbus_we  (i_dbus_we),
        .i_dbus_cyc (i_dbus_cyc),
        .o_dbus_rdt (o_dbus_rdt),
        .o_dbus_ack (o_dbus_ack),
        .o_mem_adr  (o_mem_adr),
        .o_mem_dat  (o_mem_dat),
        .o_mem_sel  (o_mem_sel),
        .o_mem_we   (o_mem_we),
        .o_mem_cyc  (o_mem_cyc),
        .i_mem_rdt  (i_mem_rdt),
        .i_mem_ack  (i_mem_ack),
        .o_timeout  (o_timeout),
        .o_busy     (o_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_ibus_adr = '0; i_ibus_cyc = 1'b0;
        i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0;
        i_dbus_we  = 1'b0; i_dbus_cyc = 1'b0;
        i_mem_rdt  = '0; i_mem_ack  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        #1;
        n_vec++;
        if (all_out !== '0) begin
            n_bad++; $display("FAIL reset_state: got %h want 0", all_out);
        end
        step();
        i_rst_n = 1'b1;
        step();
        n_vec++;
        if (all_out !== '0) begin
            n_bad++; $display("FAIL reset_release: got %h want 0", all_out);
        end
    endtask

    task automatic test_ibus_fetch();
        idle_inputs();
        i_ibus_adr = 32'h100;
        i_ibus_cyc = 1'b1;
        step();
        n_vec++;
        if (o_mem_cyc !== 1'b1 || o_mem_adr !== 32'h100 || o_mem_we !== 1'b0 ||
            o_mem_sel !== 4'hF || o_mem_dat !== 32'h0) begin
            n_bad++;
            $display("FAIL fetch_grant: cyc=%b adr=%h we=%b sel=%h dat=%h want 1/100/0/f/0",
                     o_mem_cyc, o_mem_adr, o_mem_we, o_mem_sel, o_mem_dat);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_vec++;
            if (o_mem_cyc !== 1'b1 || o_ibus_ack !== 1'b0) begin
                n_bad++; $display("FAIL fetch_wait: cyc=%b ack=%b want 1/0", o_mem_cyc, o_ibus_ack);
            end
        end
        i_mem_rdt = 32'h0000_0013;
        i_mem_ack = 1'b1;
        step();
        i_mem_ack  = 1'b0;
        i_ibus_cyc = 1'b0;
        n_vec++;
        if (o_ibus_ack !== 1'b1 || o_ibus_rdt !== 32'h13 || o_mem_cyc !== 1'b0 ||
            o_dbus_ack !== 1'b0 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL fetch_done: iack=%b rdt=%h cyc=%b dack=%b busy=%b want 1/13/0/0/1",
                     o_ibus_ack, o_ibus_rdt, o_mem_cyc, o_dbus_ack, o_busy);
        end
        step();
        n_vec++;
        if (o_ibus_ack !== 1'b0 || o_busy !== 1'b0 || o_ibus_rdt !== 32'h13) begin
            n_bad++;
            $display("FAIL fetch_idle: iack=%b busy=%b rdt=%h want 0/0/13",
                     o_ibus_ack, o_busy, o_ibus_rdt);
        end
    endtask

    task automatic test_dbus_write();
        int dacks = 0;
        int iacks = 0;
        idle_inputs();
        i_dbus_adr = 32'h2000; i_dbus_dat = 32'hDEAD_BEEF;
        i_dbus_sel = 4'h3;     i_dbus_we  = 1'b1; i_dbus_cyc = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (o_mem_cyc !== 1'b1 || o_mem_adr !== 32'h2000 || o_mem_dat !== 32'hDEAD_BEEF ||
                o_mem_sel !== 4'h3 || o_mem_we !== 1'b1) begin
                n_bad++;
                $display("FAIL dbus_hold[%0d]: cyc=%b adr=%h dat=%h sel=%h we=%b want 1/2000/deadbeef/3/1",
                         k, o_mem_cyc, o_mem_adr, o_mem_dat, o_mem_sel, o_mem_we);
            end
            // disturb the requesters; the master port must not follow
            i_dbus_adr = $urandom; i_dbus_dat = $urandom; i_dbus_sel = 4'hC;
            i_dbus_we  = 1'b0;     i_ibus_cyc = 1'b1;     i_ibus_adr = 32'h44;
            dacks += int'(o_dbus_ack);
            iacks += int'(o_ibus_ack);
            step();
        end
        i_mem_rdt = 32'h55AA_0001;
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0; i_dbus_cyc = 1'b0; i_ibus_cyc = 1'b0;
        n_vec++;
        if (o_dbus_ack !== 1'b1 || o_ibus_ack !== 1'b0 || o_dbus_rdt !== 32'h55AA_0001 ||
            o_ibus_rdt !== 32'h13) begin
            n_bad++;
            $display("FAIL dbus_done: dack=%b iack=%b drdt=%h irdt=%h want 1/0/55aa0001/13",
                     o_dbus_ack, o_ibus_ack, o_dbus_rdt, o_ibus_rdt);
        end
        dacks += int'(o_dbus_ack);
        for (int k = 0; k < 3; k++) begin
            step();
            dacks += int'(o_dbus_ack);
            iacks += int'(o_ibus_ack);
        end
        n_vec++;
        if (dacks != 1 || iacks != 0) begin
            n_bad++; $display("FAIL dbus_ack_count: dbus=%0d ibus=%0d want 1/0", dacks, iacks);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] want;
        do_reset();
        i_ibus_adr = 32'h1000; i_dbus_adr = 32'h2004;
        i_ibus_cyc = 1'b1;     i_dbus_cyc = 1'b1;
        for (int t = 0; t < 4; t++) begin
            int k = 0;
            while (o_mem_cyc !== 1'b1 && k < 10) begin
                step();
                k++;
            end
            want = (t % 2 == 0) ? 32'h2004 : 32'h1000;
            n_vec++;
            if (o_mem_cyc !== 1'b1 || o_mem_adr !== want) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: cyc=%b adr=%h want 1/%h", t, o_mem_cyc, o_mem_adr, want);
            end
            i_mem_rdt = 32'(t + 100);
            i_mem_ack = 1'b1;
            step();
            i_mem_ack = 1'b0;
            n_vec++;
            if ({o_dbus_ack, o_ibus_ack} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("FAIL rr_ack[%0d]: dack=%b iack=%b", t, o_dbus_ack, o_ibus_ack);
            end
        end
        i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        i_dbus_adr = 32'h300; i_dbus_cyc = 1'b1;
        step();
        step();
        i_rst_n = 1'b0;
        #1;
        n_vec++;
        if (all_out !== '0) begin
            n_bad++; $display("FAIL reset_mid_async: got %h want 0", all_out);
        end
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0; i_dbus_cyc = 1'b0; i_rst_n = 1'b1;
        step();
        n_vec++;
        if (o_ibus_ack !== 1'b0 || o_dbus_ack !== 1'b0 || o_mem_cyc !== 1'b0 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_stale: iack=%b dack=%b cyc=%b busy=%b want 0/0/0/0",
                     o_ibus_ack, o_dbus_ack, o_mem_cyc, o_busy);
        end
        i_ibus_adr = 32'h400; i_ibus_cyc = 1'b1;
        step();
        n_vec++;
        if (o_mem_cyc !== 1'b1 || o_mem_adr !== 32'h400 || o_mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_regrant: cyc=%b adr=%h we=%b want 1/400/0", o_mem_cyc, o_mem_adr, o_mem_we);
        end
        i_mem_rdt = 32'h77; i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0; i_ibus_cyc = 1'b0;
        n_vec++;
        if (o_ibus_ack !== 1'b1 || o_dbus_ack !== 1'b0 || o_ibus_rdt !== 32'h77) begin
            n_bad++;
            $display("FAIL reset_mid_done: iack=%b dack=%b rdt=%h want 1/0/77", o_ibus_ack, o_dbus_ack, o_ibus_rdt);
        end
        step();
    endtask

    task automatic test_spurious_ack();
        idle_inputs();
        i_mem_rdt = 32'hBAD0_BAD0;
        i_mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (o_ibus_ack !== 1'b0 || o_dbus_ack !== 1'b0 || o_ibus_rdt !== 32'h77 ||
                o_dbus_rdt !== 32'h0 || o_mem_cyc !== 1'b0 || o_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL spurious_ack[%0d]: iack=%b dack=%b irdt=%h drdt=%h cyc=%b busy=%b want 0/0/77/0/0/0",
                         k, o_ibus_ack, o_dbus_ack, o_ibus_rdt, o_dbus_rdt, o_mem_cyc, o_busy);
            end
        end
        i_mem_ack = 1'b0;
    endtask

`ifdef SERV_MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        i_dbus_adr = 32'h500; i_dbus_cyc = 1'b1;
        step();
        for (int k = 1; k <= T_CYC; k++) begin
            step();
            n_vec++;
            if (o_dbus_ack !== 1'b0 || o_timeout !== 1'b0 || o_mem_cyc !== 1'b1) begin
                n_bad++;
                $display("FAIL to_wait[%0d]: dack=%b to=%b cyc=%b want 0/0/1", k, o_dbus_ack, o_timeout, o_mem_cyc);
            end
        end
        step();
        i_dbus_cyc = 1'b0;
        n_vec++;
        if (o_dbus_ack !== 1'b1 || o_timeout !== 1'b1 || o_dbus_rdt !== 32'hFFFF_FFFF || o_mem_cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL to_expire: dack=%b to=%b rdt=%h cyc=%b want 1/1/ffffffff/0",
                     o_dbus_ack, o_timeout, o_dbus_rdt, o_mem_cyc);
        end
        step();
        n_vec++;
        if (o_timeout !== 1'b0 || o_dbus_ack !== 1'b0) begin
            n_bad++; $display("FAIL to_pulse: to=%b dack=%b want 0/0", o_timeout, o_dbus_ack);
        end
        i_dbus_cyc = 1'b1;
        step();
        for (int k = 0; k < T_CYC; k++) step();
        i_mem_rdt = 32'h1234; i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0; i_dbus_cyc = 1'b0;
        n_vec++;
        if (o_dbus_ack !== 1'b1 || o_timeout !== 1'b0 || o_dbus_rdt !== 32'h1234) begin
            n_bad++;
            $display("FAIL to_ack_wins: dack=%b to=%b rdt=%h want 1/0/1234", o_dbus_ack, o_timeout, o_dbus_rdt);
        end
        step();
        step();
    endtask
`else
    task automatic test_no_timeout();
        bit bad = 1'b0;
        idle_inputs();
        i_dbus_adr = 32'h600; i_dbus_cyc = 1'b1;
        step();
        for (int k = 0; k < 300; k++) begin
            if (o_timeout !== 1'b0 || o_dbus_ack !== 1'b0 || o_mem_cyc !== 1'b1) bad = 1'b1;
            step();
        end
        n_vec++;
        if (bad) begin
            n_bad++; $display("FAIL no_timeout: BUSY ended without ack (to=%b cyc=%b)", o_timeout, o_mem_cyc);
        end
        i_mem_rdt = 32'h600D; i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0; i_dbus_cyc = 1'b0;
        n_vec++;
        if (o_dbus_ack !== 1'b1 || o_dbus_rdt !== 32'h600D || o_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL no_timeout_done: dack=%b rdt=%h to=%b want 1/600d/0", o_dbus_ack, o_dbus_rdt, o_timeout);
        end
        step();
    endtask
`endif

    // Reference: at most one transaction in flight; a grant is taken from IDLE,
    // finished by an ack (or watchdog), followed by one dead cycle.
    task automatic test_random();
        int          phase = 0;     // 0 idle, 1 in flight, 2 dead cycle
        int          waited = 0;
        bit          owner_d = 1'b0; // starts as "ibus last", so dbus wins first tie
        logic [31:0] m_adr = '0, m_dat = '0, m_irdt = '0, m_drdt = '0;
        logic [3:0]  m_sel = '0;
        logic        m_we = 1'b0, m_cyc = 1'b0, m_iack, m_dack, m_to;
        logic [31:0] s_iadr, s_dadr, s_ddat, s_rdt;
        logic [3:0]  s_sel;
        logic        s_ic, s_dc, s_we, s_ack;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            i_ibus_cyc = ($urandom_range(0, 2) != 0);
            i_dbus_cyc = ($urandom_range(0, 2) != 0);
            i_ibus_adr = $urandom;  i_dbus_adr = $urandom;  i_dbus_dat = $urandom;
            i_dbus_sel = 4'($urandom_range(0, 15));
            i_dbus_we  = 1'($urandom_range(0, 1));
            i_mem_ack  = ($urandom_range(0, 3) == 0);
            i_mem_rdt  = $urandom;
            s_iadr = i_ibus_adr; s_dadr = i_dbus_adr; s_ddat = i_dbus_dat; s_sel = i_dbus_sel;
            s_ic = i_ibus_cyc;   s_dc = i_dbus_cyc;   s_we = i_dbus_we;
            s_ack = i_mem_ack;   s_rdt = i_mem_rdt;
            step();
            m_iack = 1'b0; m_dack = 1'b0; m_to = 1'b0;
            if (phase == 0) begin
                if (s_ic || s_dc) begin
                    owner_d = s_dc && (!s_ic || !owner_d);
                    m_adr = owner_d ? s_dadr : s_iadr;
                    m_dat = owner_d ? s_ddat : 32'h0;
                    m_sel = owner_d ? s_sel  : 4'hF;
                    m_we  = owner_d ? s_we   : 1'b0;
                    m_cyc = 1'b1;
                    waited = 0;
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (s_ack || (TO_EN && waited == T_CYC)) begin
                    m_to  = !s_ack;
                    m_cyc = 1'b0;
                    if (owner_d) begin m_drdt = s_ack ? s_rdt : 32'hFFFF_FFFF; m_dack = 1'b1; end
                    else         begin m_irdt = s_ack ? s_rdt : 32'hFFFF_FFFF; m_iack = 1'b1; end
                    phase = 2;
                end else begin
                    waited++;
                end
            end else begin
                phase = 0;
            end
            n_vec++;
            if ({o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_timeout, o_busy} !==
                {m_irdt, m_iack, m_drdt, m_dack, m_to, (phase != 0)}) begin
                n_bad++;
                $display("FAIL rand_resp[%0d]: irdt=%h iack=%b drdt=%h dack=%b to=%b busy=%b want %h/%b/%h/%b/%b/%b",
                         c, o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_timeout, o_busy,
                         m_irdt, m_iack, m_drdt, m_dack, m_to, (phase != 0));
            end
            n_vec++;
            if ({o_mem_adr, o_mem_dat, o_mem_sel, o_mem_we, o_mem_cyc} !==
                {m_adr, m_dat, m_sel, m_we, m_cyc}) begin
                n_bad++;
                $display("FAIL rand_mem[%0d]: adr=%h dat=%h sel=%h we=%b cyc=%b want %h/%h/%h/%b/%b",
                         c, o_mem_adr, o_mem_dat, o_mem_sel, o_mem_we, o_mem_cyc,
                         m_adr, m_dat, m_sel, m_we, m_cyc);
            end
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish (vectors=%0d)", n_vec);
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_ibus_fetch();
        test_dbus_write();
        test_round_robin();
        test_reset_mid();
        test_spurious_ack();
`ifdef SERV_MEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
